pci_bus_arbiter: RTL and testbench

Central arbiter for the shared initiator bus. Three masters drive frame/irdy onto the bus, and this block grants ownership to one of them using rotating round-robin priority. It supervises each grant with a start timeout and a latency timer. The owner index it produces drives the glue data mux select path.

---
 rtl/pci_bus_arbiter_if.sv | 20 ++
 rtl/pci_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_pci_bus_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pci_bus_arbiter_if.sv
// Initiator-bus signal bundle shared by the three masters and the central arbiter.
interface pci_bus_arbiter_if;
    logic [2:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [2:0] gnt_n;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout_err;

    modport master (
        output req_n, frame_n, irdy_n,
        input  gnt_n, owner, bus_busy, timeout_err
    );

    modport slave (
        input  req_n, frame_n, irdy_n,
        output gnt_n, owner, bus_busy, timeout_err
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin arbiter for three bus initiators, with a grant-start timeout and
// a latency timer that withdraws the grant from a long transfer when others wait.
module pci_bus_arbiter #(
    parameter int GNT_TIMEOUT = 8,
    parameter int MAX_XFER    = 16
) (
    input  logic              clk,
    input  logic              rst,
    pci_bus_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_TURN  = 2'd3;

    localparam logic [7:0] TO_LAST  = 8'(GNT_TIMEOUT - 1);
    localparam logic [7:0] XFER_MAX = 8'(MAX_XFER);

    logic [1:0] state;
    logic [1:0] last;
    logic [7:0] cnt;
    logic [2:0] gnt_n_q;
    logic [1:0] owner_q;
    logic       busy_q;
    logic       terr_q;

    logic [2:0] req;
    logic [3:0] req_ext;
    logic       bus_idle;
    logic [1:0] sel;
    logic       own_req;
    logic       others_req;

    // Search order starts just after the last owner, wrapping modulo 3.
    function automatic logic [1:0] pick_next(input logic [1:0] prev, input logic [2:0] r);
        logic [3:0] rx;
        logic [1:0] idx;
        rx        = {1'b0, r};
        idx       = prev;
        pick_next = 2'b11;
        for (int k = 0; k < 3; k++) begin
            idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
            if (rx[idx] && pick_next == 2'b11)
                pick_next = idx;
        end
    endfunction

    assign req        = ~bus.req_n;
    assign req_ext    = {1'b0, req};
    assign bus_idle   = bus.frame_n & bus.irdy_n;
    assign sel        = pick_next(last, req);
    assign own_req    = req_ext[owner_q];
    assign others_req = |(req & ~(3'b001 << owner_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            last    <= 2'd2;
            cnt     <= 8'd0;
            gnt_n_q <= 3'b111;
            owner_q <= 2'b11;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req && bus_idle) begin
                        gnt_n_q <= ~(3'b001 << sel);
                        owner_q <= sel;
                        cnt     <= 8'd0;
                        state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // A started frame wins over a same-cycle request withdrawal.
                    if (!bus.frame_n) begin
                        state  <= S_XFER;
                        cnt    <= 8'd0;
                        busy_q <= 1'b1;
                    end else if (!own_req || cnt == TO_LAST) begin
                        terr_q  <= own_req;
                        gnt_n_q <= 3'b111;
                        owner_q <= 2'b11;
                        last    <= owner_q;
                        state   <= S_TURN;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_XFER: begin
                    if (bus_idle) begin
                        gnt_n_q <= 3'b111;
                        owner_q <= 2'b11;
                        busy_q  <= 1'b0;
                        last    <= owner_q;
                        state   <= S_TURN;
                    end else begin
                        if (cnt < XFER_MAX)
                            cnt <= cnt + 8'd1;
                        // Latency timer: the owner keeps the bus only to finish its transaction.
                        if (cnt >= XFER_MAX && others_req)
                            gnt_n_q <= 3'b111;
                    end
                end
                S_TURN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_n       = gnt_n_q;
    assign bus.owner       = owner_q;
    assign bus.bus_busy    = busy_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter with GNT_TIMEOUT=4 and MAX_XFER=4.
module tb_pci_bus_arbiter;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic prev_terr;

    pci_bus_arbiter_if bus();

    pci_bus_arbiter #(.GNT_TIMEOUT(4), .MAX_XFER(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] req_after);
        @(negedge clk);
        rst = 1'b1;
        bus.req_n   = req_after;
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs a 3-cycle transfer for the current owner, then checks TURN and IDLE.
    task automatic do_xfer(input string tag);
        bus.frame_n = 1'b0;
        bus.irdy_n  = 1'b0;
        step();
        chk({tag, "_busy"}, {3'b0, bus.bus_busy}, 4'd1);
        step();
        step();
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        step();
        chk({tag, "_turn_gnt"}, {1'b0, bus.gnt_n}, 4'b0111);
        chk({tag, "_turn_own"}, {2'b0, bus.owner}, 4'b0011);
        chk({tag, "_turn_busy"}, {3'b0, bus.bus_busy}, 4'd0);
        step();
        chk({tag, "_idle_gnt"}, {1'b0, bus.gnt_n}, 4'b0111);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            n_total++;
            assert (bus.gnt_n == 3'b111 || $onehot(~bus.gnt_n) &&
                    !(prev_terr && bus.timeout_err) &&
                    !(bus.gnt_n == 3'b111 && !bus.bus_busy && bus.owner != 2'b11)) n_pass++;
            else $error("FAIL invariant: gnt_n %b owner %b busy %b terr %b prev_terr %b",
                        bus.gnt_n, bus.owner, bus.bus_busy, bus.timeout_err, prev_terr);
            prev_terr = bus.timeout_err;
        end else begin
            prev_terr = 1'b0;
        end
    end

    initial begin
        n_pass      = 0;
        n_total     = 0;
        prev_terr   = 1'b0;
        rst         = 1'b1;
        bus.req_n   = 3'b111;
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;

        step();
        chk("rst_gnt",  {1'b0, bus.gnt_n}, 4'b0111);
        chk("rst_own",  {2'b0, bus.owner}, 4'b0011);
        chk("rst_busy", {3'b0, bus.bus_busy}, 4'd0);
        chk("rst_terr", {3'b0, bus.timeout_err}, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single request
        bus.req_n = 3'b110;
        step();
        chk("single_gnt", {1'b0, bus.gnt_n}, 4'b0110);
        chk("single_own", {2'b0, bus.owner}, 4'd0);
        step();
        chk("single_hold", {1'b0, bus.gnt_n}, 4'b0110);
        bus.frame_n = 1'b0;
        step();
        chk("single_busy", {3'b0, bus.bus_busy}, 4'd1);
        chk("single_xgnt", {1'b0, bus.gnt_n}, 4'b0110);
        bus.req_n  = 3'b111;
        bus.irdy_n = 1'b0;
        step();
        step();
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        step();
        chk("single_turn_gnt",  {1'b0, bus.gnt_n}, 4'b0111);
        chk("single_turn_own",  {2'b0, bus.owner}, 4'b0011);
        chk("single_turn_busy", {3'b0, bus.bus_busy}, 4'd0);
        step();
        chk("single_idle_gnt", {1'b0, bus.gnt_n}, 4'b0111);

        // Round-robin with all masters requesting
        do_reset(3'b000);
        step();
        chk("rr0_gnt", {1'b0, bus.gnt_n}, 4'b0110);
        do_xfer("rr0");
        step();
        chk("rr1_gnt", {1'b0, bus.gnt_n}, 4'b0101);
        chk("rr1_own", {2'b0, bus.owner}, 4'd1);
        do_xfer("rr1");
        step();
        chk("rr2_gnt", {1'b0, bus.gnt_n}, 4'b0011);
        chk("rr2_own", {2'b0, bus.owner}, 4'd2);
        do_xfer("rr2");
        step();
        chk("rr3_gnt", {1'b0, bus.gnt_n}, 4'b0110);
        chk("rr3_own", {2'b0, bus.owner}, 4'd0);

        // Grant timeout: master 1 never starts a frame
        do_reset(3'b101);
        step();
        chk("to_gnt1", {1'b0, bus.gnt_n}, 4'b0101);
        step();
        step();
        step();
        chk("to_gnt4",  {1'b0, bus.gnt_n}, 4'b0101);
        chk("to_terr4", {3'b0, bus.timeout_err}, 4'd0);
        bus.req_n = 3'b001;
        step();
        chk("to_drop", {1'b0, bus.gnt_n}, 4'b0111);
        chk("to_own",  {2'b0, bus.owner}, 4'b0011);
        chk("to_terr", {3'b0, bus.timeout_err}, 4'd1);
        step();
        chk("to_terr_clr", {3'b0, bus.timeout_err}, 4'd0);
        step();
        chk("to_next_gnt", {1'b0, bus.gnt_n}, 4'b0011);
        chk("to_next_own", {2'b0, bus.owner}, 4'd2);

        // Latency timer: master 0 transfers 10 cycles while master 1 waits
        do_reset(3'b110);
        step();
        chk("lt_gnt", {1'b0, bus.gnt_n}, 4'b0110);
        bus.frame_n = 1'b0;
        bus.irdy_n  = 1'b0;
        bus.req_n   = 3'b100;
        step();
        chk("lt_busy", {3'b0, bus.bus_busy}, 4'd1);
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 3)
                chk("lt_held", {1'b0, bus.gnt_n}, 4'b0110);
            if (i == 5) begin
                chk("lt_revoked", {1'b0, bus.gnt_n}, 4'b0111);
                chk("lt_own",     {2'b0, bus.owner}, 4'd0);
            end
            if (i == 9)
                chk("lt_busy_end", {3'b0, bus.bus_busy}, 4'd1);
        end
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        step();
        chk("lt_turn_busy", {3'b0, bus.bus_busy}, 4'd0);
        chk("lt_turn_own",  {2'b0, bus.owner}, 4'b0011);
        step();
        chk("lt_idle_gnt", {1'b0, bus.gnt_n}, 4'b0111);
        step();
        chk("lt_m1_gnt", {1'b0, bus.gnt_n}, 4'b0101);
        chk("lt_m1_own", {2'b0, bus.owner}, 4'd1);

        // Request withdrawn before frame, then same-cycle withdraw with frame
        bus.req_n = 3'b111;
        step();
        chk("wd_gnt",  {1'b0, bus.gnt_n}, 4'b0111);
        chk("wd_own",  {2'b0, bus.owner}, 4'b0011);
        chk("wd_terr", {3'b0, bus.timeout_err}, 4'd0);
        step();
        bus.req_n = 3'b101;
        step();
        chk("wd2_gnt", {1'b0, bus.gnt_n}, 4'b0101);
        bus.req_n   = 3'b111;
        bus.frame_n = 1'b0;
        bus.irdy_n  = 1'b0;
        step();
        chk("wd2_busy", {3'b0, bus.bus_busy}, 4'd1);
        chk("wd2_gnt_held", {1'b0, bus.gnt_n}, 4'b0101);
        chk("wd2_own", {2'b0, bus.owner}, 4'd1);

        // Asynchronous reset in the middle of a transfer
        bus.req_n = 3'b000;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_gnt",  {1'b0, bus.gnt_n}, 4'b0111);
        chk("ar_own",  {2'b0, bus.owner}, 4'b0011);
        chk("ar_busy", {3'b0, bus.bus_busy}, 4'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        step();
        chk("ar_first_gnt", {1'b0, bus.gnt_n}, 4'b0110);
        chk("ar_first_own", {2'b0, bus.owner}, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
